// File: rtl/noc_credit_link_buffer.sv
// Router-to-router link stage: elastic flit FIFO, downstream credit tracking,
// retiming on the forward and credit-return paths, traffic counters and
// sticky protocol-error flags.
module noc_credit_link_buffer #(
  parameter int unsigned FLIT_WIDTH         = 64,
  parameter int unsigned DEST_WIDTH         = 6,
  parameter int unsigned BUFFER_DEPTH       = 4,
  parameter int unsigned DOWNSTREAM_CREDITS = 2,
  parameter int unsigned NUM_PIPELINE       = 1,
  parameter int unsigned STAT_WIDTH         = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [FLIT_WIDTH-1:0]                     data_in,
  input  logic [DEST_WIDTH-1:0]                     dest_in,
  input  logic                                      is_tail_in,
  input  logic                                      send_in,
  output logic                                      credit_out,
  output logic [FLIT_WIDTH-1:0]                     data_out,
  output logic [DEST_WIDTH-1:0]                     dest_out,
  output logic                                      is_tail_out,
  output logic                                      send_out,
  input  logic                                      credit_in,
  input  logic                                      err_clr,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]         occupancy,
  output logic [$clog2(DOWNSTREAM_CREDITS+1)-1:0]   credit_count,
  output logic [STAT_WIDTH-1:0]                     flit_count,
  output logic [STAT_WIDTH-1:0]                     packet_count,
  output logic                                      err_overflow,
  output logic                                      err_credit
);

  localparam int unsigned OCC_W   = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned CRED_W  = $clog2(DOWNSTREAM_CREDITS + 1);
  localparam int unsigned PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;

  logic [ENTRY_W-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ_q;
  logic [CRED_W-1:0]  cred_q;
  logic               empty, full, pop, push, ovf_evt, cred_evt;
  logic [ENTRY_W-1:0] head;

  // Forward stages: index 0 is loaded by a pop, index NUM_PIPELINE drives the outputs.
  logic [NUM_PIPELINE:0] fw_send;
  logic [FLIT_WIDTH-1:0] fw_data [NUM_PIPELINE+1];
  logic [DEST_WIDTH-1:0] fw_dest [NUM_PIPELINE+1];
  logic [NUM_PIPELINE:0] fw_tail;
  logic [NUM_PIPELINE:0] cr_pipe;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pop/push decisions; a pop while full frees the slot for a same-cycle write.
  always_comb begin
    empty    = (occ_q == '0);
    full     = (occ_q == OCC_W'(BUFFER_DEPTH));
    pop      = !empty && (cred_q != '0);
    push     = send_in && (!full || pop);
    ovf_evt  = send_in && full && !pop;
    cred_evt = credit_in && !pop && (cred_q == CRED_W'(DOWNSTREAM_CREDITS));
    head     = mem[rd_ptr];
  end

  // FIFO storage write port (payload needs no reset).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Downstream credit counter; saturates at the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred_q <= CRED_W'(DOWNSTREAM_CREDITS);
    end else begin
      case ({credit_in, pop})
        2'b10:   if (!cred_evt) cred_q <= cred_q + CRED_W'(1);
        2'b01:   cred_q <= cred_q - CRED_W'(1);
        default: cred_q <= cred_q;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      err_overflow <= ovf_evt  | (err_overflow & ~err_clr);
      err_credit   <= cred_evt | (err_credit   & ~err_clr);
    end
  end

  // Traffic counters, counted at the pop (wrap naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_count   <= '0;
      packet_count <= '0;
    end else if (pop) begin
      flit_count <= flit_count + STAT_WIDTH'(1);
      if (head[0]) packet_count <= packet_count + STAT_WIDTH'(1);
    end
  end

  // Forward register chain; stage 0 holds its payload between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_send <= '0;
      fw_tail <= '0;
      for (int unsigned i = 0; i <= NUM_PIPELINE; i++) begin
        fw_data[i] <= '0;
        fw_dest[i] <= '0;
      end
    end else begin
      fw_send[0] <= pop;
      if (pop) begin
        fw_data[0] <= head[ENTRY_W-1 -: FLIT_WIDTH];
        fw_dest[0] <= head[DEST_WIDTH:1];
        fw_tail[0] <= head[0];
      end
      for (int unsigned i = 1; i <= NUM_PIPELINE; i++) begin
        fw_send[i] <= fw_send[i-1];
        fw_data[i] <= fw_data[i-1];
        fw_dest[i] <= fw_dest[i-1];
        fw_tail[i] <= fw_tail[i-1];
      end
    end
  end

  // Credit-return chain: one pulse per pop, same depth as the forward path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_pipe <= '0;
    end else begin
      cr_pipe[0] <= pop;
      for (int unsigned i = 1; i <= NUM_PIPELINE; i++) cr_pipe[i] <= cr_pipe[i-1];
    end
  end

  // Output mapping.
  always_comb begin
    send_out     = fw_send[NUM_PIPELINE];
    data_out     = fw_data[NUM_PIPELINE];
    dest_out     = fw_dest[NUM_PIPELINE];
    is_tail_out  = fw_tail[NUM_PIPELINE];
    credit_out   = cr_pipe[NUM_PIPELINE];
    occupancy    = occ_q;
    credit_count = cred_q;
  end

endmodule

// File: tb/tb_noc_credit_link_buffer.sv
// Directed bench: instance A uses default parameters, instance B uses
// BUFFER_DEPTH=3, DOWNSTREAM_CREDITS=1, NUM_PIPELINE=0.
module tb_noc_credit_link_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [63:0] a_data_in, a_data_out;
  logic [5:0]  a_dest_in, a_dest_out;
  logic        a_is_tail_in, a_send_in, a_credit_out, a_is_tail_out, a_send_out;
  logic        a_credit_in, a_err_clr, a_err_overflow, a_err_credit;
  logic [2:0]  a_occupancy;
  logic [1:0]  a_credit_count;
  logic [15:0] a_flit_count, a_packet_count;

  logic [63:0] b_data_in, b_data_out;
  logic [5:0]  b_dest_in, b_dest_out;
  logic        b_is_tail_in, b_send_in, b_credit_out, b_is_tail_out, b_send_out;
  logic        b_credit_in, b_err_clr, b_err_overflow, b_err_credit;
  logic [1:0]  b_occupancy;
  logic [0:0]  b_credit_count;
  logic [15:0] b_flit_count, b_packet_count;

  noc_credit_link_buffer u_a (
    .clk(clk), .rst_n(rst_n),
    .data_in(a_data_in), .dest_in(a_dest_in), .is_tail_in(a_is_tail_in), .send_in(a_send_in),
    .credit_out(a_credit_out),
    .data_out(a_data_out), .dest_out(a_dest_out), .is_tail_out(a_is_tail_out), .send_out(a_send_out),
    .credit_in(a_credit_in), .err_clr(a_err_clr),
    .occupancy(a_occupancy), .credit_count(a_credit_count),
    .flit_count(a_flit_count), .packet_count(a_packet_count),
    .err_overflow(a_err_overflow), .err_credit(a_err_credit)
  );

  noc_credit_link_buffer #(
    .BUFFER_DEPTH(3), .DOWNSTREAM_CREDITS(1), .NUM_PIPELINE(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .data_in(b_data_in), .dest_in(b_dest_in), .is_tail_in(b_is_tail_in), .send_in(b_send_in),
    .credit_out(b_credit_out),
    .data_out(b_data_out), .dest_out(b_dest_out), .is_tail_out(b_is_tail_out), .send_out(b_send_out),
    .credit_in(b_credit_in), .err_clr(b_err_clr),
    .occupancy(b_occupancy), .credit_count(b_credit_count),
    .flit_count(b_flit_count), .packet_count(b_packet_count),
    .err_overflow(b_err_overflow), .err_credit(b_err_credit)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int pulses, cr_pulses, owed, sent, got, j;
    logic [63:0] exp_q[$];
    logic [63:0] drain_exp [3];

    rst_n = 1'b0;
    a_data_in = '0; a_dest_in = '0; a_is_tail_in = 0; a_send_in = 0; a_credit_in = 0; a_err_clr = 0;
    b_data_in = '0; b_dest_in = '0; b_is_tail_in = 0; b_send_in = 0; b_credit_in = 0; b_err_clr = 0;

    // Reset state
    repeat (2) step();
    check("rst_a_send",  a_send_out, 0);
    check("rst_a_cred_out", a_credit_out, 0);
    check("rst_a_data",  a_data_out, 0);
    check("rst_a_occ",   a_occupancy, 0);
    check("rst_a_cred",  a_credit_count, 2);
    check("rst_a_flits", a_flit_count, 0);
    check("rst_a_errs",  {a_err_overflow, a_err_credit}, 0);
    check("rst_b_cred",  b_credit_count, 1);
    rst_n = 1'b1;
    step();

    // Single flit through defaults: 3-cycle latency, credit_out aligned
    a_send_in = 1; a_data_in = 64'hA5; a_dest_in = 6'd5; a_is_tail_in = 1;
    step();
    a_send_in = 0; a_is_tail_in = 0;
    check("t1_occ1", a_occupancy, 1);
    check("t1_send_early1", a_send_out, 0);
    step();
    check("t1_occ0", a_occupancy, 0);
    check("t1_cred1", a_credit_count, 1);
    check("t1_send_early2", a_send_out, 0);
    step();
    check("t1_send", a_send_out, 1);
    check("t1_data", a_data_out, 64'hA5);
    check("t1_dest", a_dest_out, 5);
    check("t1_tail", a_is_tail_out, 1);
    check("t1_credit_out", a_credit_out, 1);
    check("t1_pkt", a_packet_count, 1);
    check("t1_flit", a_flit_count, 1);
    step();
    check("t1_send_one_cycle", a_send_out, 0);
    check("t1_credit_one_cycle", a_credit_out, 0);

    // Credit stall: restore credit to 2, then send 4 with no credits returned
    a_credit_in = 1;
    step();
    a_credit_in = 0;
    check("t2_cred_restored", a_credit_count, 2);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      a_send_in = 1; a_data_in = 64'hB0 + 64'(i); a_is_tail_in = (i == 3);
      step();
      if (a_send_out) pulses++;
    end
    a_send_in = 0; a_is_tail_in = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_send_out) pulses++;
    end
    check("t2_pulses", pulses, 2);
    check("t2_occ", a_occupancy, 2);
    check("t2_cred0", a_credit_count, 0);
    a_credit_in = 1;
    step();
    a_credit_in = 0;
    check("t2_wait1", a_send_out, 0);
    step();
    check("t2_wait2", a_send_out, 0);
    step();
    check("t2_send", a_send_out, 1);
    check("t2_data", a_data_out, 64'hB2);
    check("t2_occ1", a_occupancy, 1);

    // Simultaneous credit_in and pop at credit_count=1
    a_credit_in = 1;
    step();
    step();
    a_credit_in = 0;
    check("t3_cred_hold", a_credit_count, 1);
    check("t3_occ0", a_occupancy, 0);
    step();
    check("t3_send", a_send_out, 1);
    check("t3_data", a_data_out, 64'hB3);
    check("t3_pkt", a_packet_count, 2);
    check("t3_flit", a_flit_count, 5);
    // Credit overflow at full count
    a_credit_in = 1;
    step();
    check("t3_cred2", a_credit_count, 2);
    check("t3_no_err", a_err_credit, 0);
    step();
    a_credit_in = 0;
    check("t3_err_credit", a_err_credit, 1);
    check("t3_cred_sat", a_credit_count, 2);
    a_err_clr = 1;
    step();
    a_err_clr = 0;
    check("t3_err_clr", a_err_credit, 0);
    check("t3_no_ovf", a_err_overflow, 0);

    // Instance B: fill to full, overflow, latency 2 with NUM_PIPELINE=0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b_send_in = 1; b_data_in = 64'h10 + 64'(i);
      step();
      if (i == 0) check("t4_lat_early", b_send_out, 0);
      if (i == 1) begin
        check("t4_lat2_send", b_send_out, 1);
        check("t4_lat2_data", b_data_out, 64'h10);
      end
    end
    b_send_in = 0;
    check("t4_occ_full", b_occupancy, 3);
    check("t4_err_ovf", b_err_overflow, 1);
    check("t4_cred0", b_credit_count, 0);
    b_err_clr = 1;
    step();
    b_err_clr = 0;
    check("t4_ovf_clr", b_err_overflow, 0);
    // Push and pop together while full
    b_credit_in = 1;
    step();
    b_credit_in = 0;
    b_send_in = 1; b_data_in = 64'h15;
    step();
    b_send_in = 0;
    check("t4_full_pp_occ", b_occupancy, 3);
    check("t4_full_pp_noovf", b_err_overflow, 0);
    check("t4_full_pp_send", b_send_out, 1);
    check("t4_full_pp_data", b_data_out, 64'h11);
    // Drain: dropped 0x14 must never appear
    drain_exp[0] = 64'h12; drain_exp[1] = 64'h13; drain_exp[2] = 64'h15;
    owed = 1; j = 0;
    for (int k = 0; k < 12; k++) begin
      b_credit_in = (owed > 0);
      if (owed > 0) owed--;
      step();
      if (b_send_out) begin
        if (j < 3) check("t4_drain_data", b_data_out, drain_exp[j]);
        else check("t4_drain_extra", b_data_out, 64'hFFFF);
        j++;
        owed++;
      end
    end
    b_credit_in = 0;
    check("t4_drain_count", j, 3);
    check("t4_drain_occ", b_occupancy, 0);
    check("t4_no_err_credit", b_err_credit, 0);

    // Instance B: 20 flits, random credit returns, pointer wrap on depth 3
    do_reset();
    owed = 0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      if (owed > 0 && $urandom_range(0, 1) == 1) begin
        b_credit_in = 1; owed--;
      end else begin
        b_credit_in = 0;
      end
      if (sent < 20 && b_occupancy < 2'd3) begin
        b_send_in = 1; b_data_in = 64'h100 + 64'(sent); b_is_tail_in = (sent % 4 == 3);
        exp_q.push_back(64'h100 + 64'(sent));
        sent++;
      end else begin
        b_send_in = 0; b_is_tail_in = 0;
      end
      step();
      if (b_send_out) begin
        if (exp_q.size() == 0) check("t5_spurious", b_data_out, 64'hFFFF);
        else check("t5_order", b_data_out, exp_q.pop_front());
        owed++;
        got++;
      end
    end
    b_send_in = 0; b_credit_in = 0; b_is_tail_in = 0;
    check("t5_got_all", got, 20);
    check("t5_flit_count", b_flit_count, 20);
    check("t5_pkt_count", b_packet_count, 5);
    check("t5_no_ovf", b_err_overflow, 0);
    check("t5_no_err_credit", b_err_credit, 0);
    check("t5_occ0", b_occupancy, 0);

    // Instance A: asynchronous reset with flits buffered and one in flight
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a_send_in = 1; a_data_in = 64'hC0 + 64'(i);
      step();
    end
    a_send_in = 0;
    check("t6_occ3", a_occupancy, 3);
    check("t6_cred0", a_credit_count, 0);
    a_credit_in = 1;
    step();
    a_credit_in = 0;
    step();
    rst_n = 1'b0;
    #1;
    check("t6_async_send", a_send_out, 0);
    check("t6_async_credit_out", a_credit_out, 0);
    check("t6_async_data", a_data_out, 0);
    check("t6_async_occ", a_occupancy, 0);
    check("t6_async_cred", a_credit_count, 2);
    check("t6_async_flits", a_flit_count, 0);
    check("t6_async_pkts", a_packet_count, 0);
    rst_n = 1'b1;
    pulses = 0; cr_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_send_out) pulses++;
      if (a_credit_out) cr_pulses++;
    end
    check("t6_no_stale_flits", pulses, 0);
    check("t6_no_stale_credits", cr_pulses, 0);
    check("t6_cred_after", a_credit_count, 2);
    check("t6_occ_after", a_occupancy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
